// File: rtl/bakery_axil_regs.sv
// rtl/bakery_axil_regs.sv - AXI4-Lite control/status register block for one Lamport-bakery core
// Optional macro BAKERY_AXIL_WSTRB_EN: RW writes honour wstrb per byte, CONTROL acts only with wstrb[0].
module bakery_axil_regs #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] ID_VALUE = 32'hBA4E_0001
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [63:0]       addr_choosing,
  output logic [63:0]       addr_number,
  output logic [63:0]       addr_counter,
  output logic [31:0]       idx_inst,
  output logic [31:0]       idx_max,
  output logic [31:0]       nr_loops,
  output logic [31:0]       dly_cfg,
  output logic              core_start,
  input  logic              core_busy,
  input  logic              core_done
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [5:0] W_ID        = 6'h00;
  localparam logic [5:0] W_STATUS    = 6'h04;
  localparam logic [5:0] W_CONTROL   = 6'h05;

  // Word offset -> {hit, slot} into the ten RW configuration words.
  function automatic logic [4:0] cfg_map(input logic [5:0] w);
    case (w)
      6'h08:   cfg_map = {1'b1, 4'd0};
      6'h09:   cfg_map = {1'b1, 4'd1};
      6'h0A:   cfg_map = {1'b1, 4'd2};
      6'h0B:   cfg_map = {1'b1, 4'd3};
      6'h0C:   cfg_map = {1'b1, 4'd4};
      6'h0D:   cfg_map = {1'b1, 4'd5};
      6'h10:   cfg_map = {1'b1, 4'd6};
      6'h11:   cfg_map = {1'b1, 4'd7};
      6'h14:   cfg_map = {1'b1, 4'd8};
      6'h15:   cfg_map = {1'b1, 4'd9};
      default: cfg_map = 5'd0;
    endcase
  endfunction

  logic [31:0] cfg_q [10];
  logic [31:0] cfg_d [10];
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        core_start_q, core_start_d;

  logic [5:0]  aw_word, ar_word;
  logic [4:0]  aw_map, ar_map;
  logic        wr_acc, rd_acc;
  logic [31:0] wmask;
  logic        ctrl_en;
  logic        unused_bits;

  assign aw_word = s_axil_awaddr[7:2];
  assign ar_word = s_axil_araddr[7:2];
  assign aw_map  = cfg_map(aw_word);
  assign ar_map  = cfg_map(ar_word);

  // AW and W are only ever taken together, and only with no response pending.
  assign wr_acc = reset_n & s_axil_awvalid & s_axil_wvalid & ~bvalid_q;
  assign rd_acc = reset_n & s_axil_arvalid & ~rvalid_q;

`ifdef BAKERY_AXIL_WSTRB_EN
  assign wmask       = {{8{s_axil_wstrb[3]}}, {8{s_axil_wstrb[2]}},
                        {8{s_axil_wstrb[1]}}, {8{s_axil_wstrb[0]}}};
  assign ctrl_en     = s_axil_wstrb[0];
  assign unused_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};
`else
  assign wmask       = 32'hFFFF_FFFF;
  assign ctrl_en     = 1'b1;
  assign unused_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], s_axil_wstrb};
`endif

  always_comb begin
    cfg_d        = cfg_q;
    bvalid_d     = bvalid_q & ~s_axil_bready;
    bresp_d      = bresp_q;
    done_d       = done_q;
    core_start_d = 1'b0;
    if (wr_acc) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      if (aw_map[4]) begin
        cfg_d[aw_map[3:0]] = (cfg_q[aw_map[3:0]] & ~wmask) | (s_axil_wdata & wmask);
      end else if (aw_word == W_CONTROL) begin
        if (ctrl_en && s_axil_wdata[1]) done_d = 1'b0;
        if (ctrl_en && s_axil_wdata[0] && !core_busy) begin
          core_start_d = 1'b1;
          done_d       = 1'b0;
        end
      end else if (aw_word != W_ID && aw_word != W_STATUS) begin
        bresp_d = RESP_SLVERR;
      end
    end
    // A completion in the same cycle as a clear must not be lost.
    if (core_done) done_d = 1'b1;
  end

  always_comb begin
    rvalid_d = rvalid_q & ~s_axil_rready;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rd_acc) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      if (ar_map[4]) begin
        rdata_d = cfg_q[ar_map[3:0]];
      end else begin
        case (ar_word)
          W_ID:      rdata_d = ID_VALUE;
          W_STATUS:  rdata_d = {30'd0, core_busy, done_q};
          W_CONTROL: rdata_d = 32'd0;
          default: begin
            rdata_d = 32'd0;
            rresp_d = RESP_SLVERR;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q        <= '{default: 32'd0};
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      rvalid_q     <= 1'b0;
      rresp_q      <= 2'b00;
      rdata_q      <= 32'd0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      cfg_q        <= cfg_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
    end
  end

  assign s_axil_awready = wr_acc;
  assign s_axil_wready  = wr_acc;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = rd_acc;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;

  assign addr_choosing = {cfg_q[1], cfg_q[0]};
  assign addr_number   = {cfg_q[3], cfg_q[2]};
  assign addr_counter  = {cfg_q[5], cfg_q[4]};
  assign idx_inst      = cfg_q[6];
  assign idx_max       = cfg_q[7];
  assign nr_loops      = cfg_q[8];
  assign dly_cfg       = cfg_q[9];
  assign core_start    = core_start_q;

endmodule

// File: tb/tb_bakery_axil_regs.sv
// tb/tb_bakery_axil_regs.sv - randomized self-checking bench for bakery_axil_regs
module tb_bakery_axil_regs;

  localparam logic [31:0] ID = 32'hBA4E_0001;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [63:0] addr_choosing, addr_number, addr_counter;
  logic [31:0] idx_inst, idx_max, nr_loops, dly_cfg;
  logic        core_start, core_busy, core_done;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int start_hi = 0;
  int start_cyc = -1;
  logic [31:0] model [0:63];
  logic        done_exp;
  logic [7:0]  rw_addrs [10] = '{8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h40, 8'h44, 8'h50, 8'h54};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (core_start === 1'b1) begin start_hi++; start_cyc = cyc; end

  bakery_axil_regs #(.ADDR_W(8), .ID_VALUE(ID)) dut (
    .clock(clock), .reset_n(reset_n),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .addr_choosing(addr_choosing), .addr_number(addr_number), .addr_counter(addr_counter),
    .idx_inst(idx_inst), .idx_max(idx_max), .nr_loops(nr_loops), .dly_cfg(dly_cfg),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done)
  );

  function automatic logic is_rw(input int w);
    return w inside {8, 9, 10, 11, 12, 13, 16, 17, 20, 21};
  endfunction

  function automatic logic is_mapped(input int w);
    return is_rw(w) || w == 0 || w == 4 || w == 5;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
`ifdef BAKERY_AXIL_WSTRB_EN
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
`else
    return (s === 4'bxxxx) ? 32'hFFFF_FFFF : 32'hFFFF_FFFF;
`endif
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    logic [31:0] m;
    w = int'(a[7:2]);
    m = byte_mask(s);
    if (is_rw(w)) model[w] = (model[w] & ~m) | (d & m);
  endtask

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    int w;
    w = int'(a[7:2]);
    if (w == 0) return ID;
    if (w == 4) return {30'd0, core_busy, done_exp};
    if (is_rw(w)) return model[w];
    return 32'd0;
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic with_done, output logic [1:0] resp, output int acc_cyc);
    int n;
    @(negedge clock);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    if (with_done) core_done = 1'b1;
    #1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge clock); #1; n++; end
    compared++;
    if (n >= 20) begin
      mismatched++;
      $display("FAIL aw_accept addr=%h awready=%b required 1", a, awready);
    end
    @(posedge clock); #1;
    acc_cyc = cyc; awvalid = 1'b0; wvalid = 1'b0; core_done = 1'b0;
    compared++;
    if (bvalid !== 1'b1) begin
      mismatched++;
      $display("FAIL b_latency addr=%h bvalid=%b required 1 one cycle after accept", a, bvalid);
    end
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    resp = bresp; bready = 1'b1;
    @(posedge clock); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clock);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    #1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(negedge clock); #1; n++; end
    compared++;
    if (n >= 20) begin
      mismatched++;
      $display("FAIL ar_accept addr=%h arready=%b required 1", a, arready);
    end
    @(posedge clock); #1;
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    d = rdata; resp = rresp; rready = 1'b1;
    @(posedge clock); #1;
    rready = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clock); core_done = 1'b1;
    @(negedge clock); core_done = 1'b0;
    done_exp = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    reset_n = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    awaddr = 8'h40; araddr = 8'h00; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    core_busy = 1'b0; core_done = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 32'd0;
    done_exp = 1'b0;
    repeat (3) @(negedge clock);
    compared++;
    if ({awready, wready, arready, bvalid, rvalid, core_start} !== 6'd0) begin
      mismatched++;
      $display("FAIL reset_handshake got %b required 000000", {awready, wready, arready, bvalid, rvalid, core_start});
    end
    compared++;
    if ({bresp, rresp, rdata} !== 36'd0) begin
      mismatched++;
      $display("FAIL reset_resp got %h required 0", {bresp, rresp, rdata});
    end
    compared++;
    if ({addr_choosing, addr_number, addr_counter, idx_inst, idx_max, nr_loops, dly_cfg} !== 320'd0) begin
      mismatched++;
      $display("FAIL reset_cfg outputs not all zero idx_inst=%h nr_loops=%h", idx_inst, nr_loops);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    axi_read(8'h00, d, r);
    compared++;
    if ({d, r} !== {ID, 2'b00}) begin
      mismatched++;
      $display("FAIL read_id got %h/%b required %h/00", d, r, ID);
    end
    axi_read(8'h10, d, r);
    compared++;
    if ({d, r} !== 34'd0) begin
      mismatched++;
      $display("FAIL read_status_reset got %h/%b required 0/00", d, r);
    end
  endtask

  task automatic check_outputs(input string tag);
    compared++;
    if ({addr_choosing, addr_number, addr_counter, idx_inst, idx_max, nr_loops, dly_cfg} !==
        {model[9], model[8], model[11], model[10], model[13], model[12],
         model[16], model[17], model[20], model[21]}) begin
      mismatched++;
      $display("FAIL %s outputs choosing=%h idx_inst=%h idx_max=%h nr_loops=%h dly=%h required %h %h %h %h %h",
               tag, addr_choosing, idx_inst, idx_max, nr_loops, dly_cfg,
               {model[9], model[8]}, model[16], model[17], model[20], model[21]);
    end
  endtask

  task automatic readback_all(input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < 10; i++) begin
      axi_read(rw_addrs[i], d, r);
      compared++;
      if ({d, r} !== {exp_read(rw_addrs[i]), 2'b00}) begin
        mismatched++;
        $display("FAIL %s readback addr=%h got %h/%b required %h/00", tag, rw_addrs[i], d, r, exp_read(rw_addrs[i]));
      end
    end
  endtask

  task automatic test_config();
    logic [1:0]  r;
    logic [31:0] d;
    logic [7:0]  a;
    int c;
    logic [7:0]  sa [6] = '{8'h20, 8'h24, 8'h40, 8'h44, 8'h50, 8'h54};
    logic [31:0] sd [6] = '{32'hC000_1008, 32'h0, 32'd2, 32'd3, 32'd19, 32'h0000_A116};
    for (int i = 0; i < 6; i++) begin
      axi_write(sa[i], sd[i], 4'hF, 1'b0, r, c);
      model_write(sa[i], sd[i], 4'hF);
    end
    compared++;
    if ({addr_choosing, idx_inst, idx_max, nr_loops, dly_cfg} !==
        {64'h0000_0000_C000_1008, 32'd2, 32'd3, 32'd19, 32'h0000_A116}) begin
      mismatched++;
      $display("FAIL cfg_fixed choosing=%h idx=%h max=%h loops=%h dly=%h", addr_choosing, idx_inst, idx_max, nr_loops, dly_cfg);
    end
    readback_all("cfg_fixed");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = {6'($urandom_range(0, 63)), 2'b00};
      else a = rw_addrs[$urandom_range(0, 9)];
      if ($urandom_range(0, 1) == 1) begin
        if (a == 8'h14) a = 8'h20;
        d = $urandom;
        axi_write(a, d, 4'($urandom_range(0, 15)), 1'b0, r, c);
        model_write(a, d, wstrb);
        compared++;
        if (r !== (is_mapped(int'(a[7:2])) ? 2'b00 : 2'b10)) begin
          mismatched++;
          $display("FAIL rand_bresp addr=%h got %b", a, r);
        end
      end else begin
        axi_read(a, d, r);
        compared++;
        if ({d, r} !== {exp_read(a), is_mapped(int'(a[7:2])) ? 2'b00 : 2'b10}) begin
          mismatched++;
          $display("FAIL rand_read addr=%h got %h/%b required %h", a, d, r, exp_read(a));
        end
      end
    end
    check_outputs("cfg_random");
  endtask

  task automatic test_start();
    logic [1:0]  r;
    logic [31:0] d;
    int c, h;
    h = start_hi;
    axi_write(8'h14, 32'd1, 4'hF, 1'b0, r, c);
    repeat (3) @(negedge clock);
    compared++;
    if (start_hi - h !== 1 || start_cyc !== c || r !== 2'b00) begin
      mismatched++;
      $display("FAIL start_pulse cycles=%0d at=%0d resp=%b required 1 at %0d resp 00", start_hi - h, start_cyc, r, c);
    end
    done_exp = 1'b0;
    core_busy = 1'b1;
    h = start_hi;
    axi_write(8'h14, 32'd1, 4'hF, 1'b0, r, c);
    repeat (3) @(negedge clock);
    compared++;
    if (start_hi - h !== 0 || r !== 2'b00) begin
      mismatched++;
      $display("FAIL start_busy cycles=%0d resp=%b required 0 / 00", start_hi - h, r);
    end
    axi_read(8'h10, d, r);
    compared++;
    if (d !== 32'd2) begin
      mismatched++;
      $display("FAIL status_busy got %h required 2", d);
    end
    core_busy = 1'b0;
    h = start_hi;
    axi_write(8'h14, 32'd1, 4'b0010, 1'b0, r, c);
    repeat (3) @(negedge clock);
    compared++;
`ifdef BAKERY_AXIL_WSTRB_EN
    if (start_hi - h !== 0) begin
`else
    if (start_hi - h !== 1) begin
`endif
      mismatched++;
      $display("FAIL start_wstrb cycles=%0d", start_hi - h);
    end
    axi_read(8'h14, d, r);
    compared++;
    if ({d, r} !== 34'd0) begin
      mismatched++;
      $display("FAIL control_reads_zero got %h/%b required 0/00", d, r);
    end
  endtask

  task automatic test_done();
    logic [1:0]  r;
    logic [31:0] d;
    int c;
    pulse_done();
    for (int i = 0; i < 2; i++) begin
      axi_read(8'h10, d, r);
      compared++;
      if (d !== exp_read(8'h10) || d !== 32'd1) begin
        mismatched++;
        $display("FAIL done_sticky read %0d got %h required 1", i, d);
      end
    end
    axi_write(8'h14, 32'd2, 4'hF, 1'b0, r, c);
    done_exp = 1'b0;
    axi_read(8'h10, d, r);
    compared++;
    if (d !== 32'd0) begin
      mismatched++;
      $display("FAIL done_clear got %h required 0", d);
    end
    axi_write(8'h14, 32'd2, 4'hF, 1'b1, r, c);
    done_exp = 1'b1;
    axi_read(8'h10, d, r);
    compared++;
    if (d !== 32'd1) begin
      mismatched++;
      $display("FAIL done_set_wins got %h required 1", d);
    end
    axi_write(8'h14, 32'd1, 4'hF, 1'b0, r, c);
    done_exp = 1'b0;
    axi_read(8'h10, d, r);
    compared++;
    if (d !== 32'd0) begin
      mismatched++;
      $display("FAIL start_clears_done got %h required 0", d);
    end
  endtask

  task automatic test_unmapped();
    logic [1:0]  r;
    logic [31:0] d;
    int c;
    axi_read(8'h0C, d, r);
    compared++;
    if ({d, r} !== {32'd0, 2'b10}) begin
      mismatched++;
      $display("FAIL unmapped_read got %h/%b required 0/10", d, r);
    end
    axi_write(8'h60, 32'hDEAD_BEEF, 4'hF, 1'b0, r, c);
    compared++;
    if (r !== 2'b10) begin
      mismatched++;
      $display("FAIL unmapped_write resp %b required 10", r);
    end
    axi_write(8'h00, 32'h1234_5678, 4'hF, 1'b0, r, c);
    axi_read(8'h00, d, r);
    compared++;
    if ({d, r} !== {ID, 2'b00}) begin
      mismatched++;
      $display("FAIL ro_write_discard got %h/%b required %h/00", d, r, ID);
    end
    readback_all("unmapped");
    check_outputs("unmapped");
  endtask

  task automatic test_backpressure();
    logic bad;
    logic [31:0] d2;
    d2 = $urandom;
    @(negedge clock);
    awaddr = 8'h60; wdata = 32'h5555_AAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clock); #1;
    awaddr = 8'h50; wdata = d2;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0) bad = 1'b1;
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL write_backpressure bvalid=%b bresp=%b awready=%b required 1/10/0", bvalid, bresp, awready);
    end
    bready = 1'b1;
    @(posedge clock); #1;
    compared++;
    if (awready !== 1'b1) begin
      mismatched++;
      $display("FAIL write_reaccept awready=%b required 1", awready);
    end
    @(posedge clock); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(8'h50, d2, 4'hF);
    @(posedge clock); #1;
    bready = 1'b0;
    @(negedge clock);
    araddr = 8'h0C; arvalid = 1'b1; rready = 1'b0;
    @(posedge clock); #1;
    araddr = 8'h00;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (rvalid !== 1'b1 || rdata !== 32'd0 || rresp !== 2'b10 || arready !== 1'b0) bad = 1'b1;
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL read_backpressure rvalid=%b rdata=%h rresp=%b arready=%b", rvalid, rdata, rresp, arready);
    end
    rready = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    arvalid = 1'b0;
    compared++;
    if ({rvalid, rdata, rresp} !== {1'b1, ID, 2'b00}) begin
      mismatched++;
      $display("FAIL read_after_bp got %b/%h/%b required 1/%h/00", rvalid, rdata, rresp, ID);
    end
    @(posedge clock); #1;
    rready = 1'b0;
    check_outputs("backpressure");
  endtask

  task automatic test_back_to_back();
    int acc [4];
    int n;
    logic [7:0]  a;
    logic [31:0] d, rd;
    logic [1:0]  r, rr;
    int c;
    @(negedge clock);
    a = rw_addrs[$urandom_range(0, 9)]; d = $urandom;
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (awready !== 1'b1 && n < 10) begin @(negedge clock); #1; n++; end
      @(posedge clock); #1;
      acc[k] = cyc;
      model_write(a, d, 4'hF);
      if (k < 3) begin
        a = rw_addrs[$urandom_range(0, 9)]; d = $urandom;
        awaddr = a; wdata = d;
      end else begin
        awvalid = 1'b0; wvalid = 1'b0;
      end
    end
    @(posedge clock); #1;
    bready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      compared++;
      if (acc[k] - acc[k-1] !== 2) begin
        mismatched++;
        $display("FAIL b2b_spacing write %0d gap=%0d required 2", k, acc[k] - acc[k-1]);
      end
    end
    d = $urandom;
    fork
      axi_write(8'h44, d, 4'hF, 1'b0, r, c);
      axi_read(8'h40, rd, rr);
    join
    compared++;
    if ({rd, rr, r} !== {model[16], 2'b00, 2'b00}) begin
      mismatched++;
      $display("FAIL concurrent rd=%h/%b bresp=%b required %h/00/00", rd, rr, r, model[16]);
    end
    model_write(8'h44, d, 4'hF);
    check_outputs("b2b");
  endtask

  task automatic test_wstrb();
    logic [1:0]  r;
    logic [31:0] d;
    int c;
    axi_write(8'h50, 32'd19, 4'hF, 1'b0, r, c);
    axi_write(8'h50, 32'hFFFF_FFFF, 4'b0001, 1'b0, r, c);
    model_write(8'h50, 32'd19, 4'hF);
    model_write(8'h50, 32'hFFFF_FFFF, 4'b0001);
    axi_read(8'h50, d, r);
    compared++;
`ifdef BAKERY_AXIL_WSTRB_EN
    if (d !== 32'h0000_00FF || nr_loops !== 32'h0000_00FF) begin
`else
    if (d !== 32'hFFFF_FFFF || nr_loops !== 32'hFFFF_FFFF) begin
`endif
      mismatched++;
      $display("FAIL wstrb read=%h nr_loops=%h", d, nr_loops);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    awaddr = 8'h14; wdata = 32'd1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clock); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    compared++;
    if ({core_start, bvalid} !== 2'b11) begin
      mismatched++;
      $display("FAIL pre_reset start/bvalid=%b required 11", {core_start, bvalid});
    end
    reset_n = 1'b0;
    #1;
    compared++;
    if ({core_start, bvalid, bresp, idx_inst, nr_loops} !== 68'd0) begin
      mismatched++;
      $display("FAIL mid_reset start=%b bvalid=%b idx_inst=%h nr_loops=%h required all 0", core_start, bvalid, idx_inst, nr_loops);
    end
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = 32'd0;
    done_exp = 1'b0;
    readback_all("post_reset");
  endtask

  initial begin
    test_reset();
    test_config();
    test_start();
    test_done();
    test_unmapped();
    test_backpressure();
    test_back_to_back();
    test_wstrb();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached compared=%0d", compared);
    $fatal(1, "watchdog");
  end

endmodule
